// File: rtl/idelay_seq_pkg.sv
// Shared constants for the IDELAY tap sequencer: state encoding, default
// geometry and the masked-channel search used to walk channels in order.
package idelay_seq_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TAP_W  = 5;
  localparam int MAX_CH     = 32;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_RDY = 3'd1;
  localparam logic [2:0] S_LOAD     = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_CHECK    = 3'd4;
  localparam logic [2:0] S_DWELL    = 3'd5;
  localparam logic [2:0] S_RESTORE  = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  // Lowest set mask bit at index >= from; returns {found, index}.
  function automatic logic [5:0] next_masked(input logic [MAX_CH-1:0] mask,
                                             input logic [5:0]        from);
    logic [5:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (6'(i) >= from)) r = {1'b1, 5'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/idelay_tap_sequencer.sv
// Drives ldcnt/dicnt of io_delay_module: single-tap load with readback check,
// or a full 0..TAP_MAX sweep with per-step dwell followed by a restore pass.
module idelay_tap_sequencer
  import idelay_seq_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int TAP_W         = DEF_TAP_W,
  parameter int SETTLE_CYCLES = 4,
  parameter int DWELL_CYCLES  = 16,
  parameter int CNT_W         = 16
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    rdy,
  input  logic                    start,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [TAP_W-1:0]        tap_target,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_CH-1:0]       err_ch,
  output logic                    err_rdy,
  output logic [NUM_CH-1:0]       ldcnt,
  output logic [NUM_CH*TAP_W-1:0] dicnt,
  input  logic [NUM_CH*TAP_W-1:0] docnt,
  output logic [TAP_W-1:0]        cur_tap,
  output logic                    step_stb,
  output logic [2:0]              dbg_state
);

  localparam logic [TAP_W-1:0] TAP_MAX = '1;

  logic [2:0]              state_q, state_d;
  logic                    mode_q, mode_d;
  logic [NUM_CH-1:0]       mask_q, mask_d;
  logic [TAP_W-1:0]        target_q, target_d;
  logic [4:0]              ch_q, ch_d;
  logic [TAP_W-1:0]        cur_tap_q, cur_tap_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0]       err_ch_q, err_ch_d;
  logic                    err_rdy_q, err_rdy_d;
  logic [NUM_CH-1:0]       ldcnt_q, ldcnt_d;
  logic [NUM_CH*TAP_W-1:0] dicnt_q, dicnt_d;
  logic                    step_q, step_d;
  logic                    restore_q, restore_d;

  logic                    accept, do_load;
  logic [4:0]              load_ch;
  logic [TAP_W-1:0]        load_tap;
  logic                    src_mode;
  logic [NUM_CH-1:0]       src_mask;
  logic [TAP_W-1:0]        src_tap;
  logic [5:0]              first, nxt, first_src;

  // Handshake: start is a request sampled only in IDLE; busy acknowledges it
  // from the next cycle through DONE, and requests while busy are dropped.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    target_d  = target_q;
    ch_d      = ch_q;
    cur_tap_d = cur_tap_q;
    cnt_d     = cnt_q;
    err_ch_d  = err_ch_q;
    err_rdy_d = err_rdy_q;
    ldcnt_d   = '0;
    dicnt_d   = dicnt_q;
    step_d    = 1'b0;
    restore_d = restore_q;
    accept    = 1'b0;
    do_load   = 1'b0;
    load_ch   = '0;
    load_tap  = cur_tap_q;
    src_mode  = mode_q;
    src_mask  = mask_q;
    src_tap   = target_q;
    first_src = '0;
    first     = next_masked(MAX_CH'(mask_q), 6'd0);
    nxt       = next_masked(MAX_CH'(mask_q), {1'b0, ch_q} + 6'd1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          mask_d   = ch_mask;
          target_d = tap_target;
          src_mode = mode;
          src_mask = ch_mask;
          src_tap  = tap_target;
          if (rdy) accept = 1'b1;
          else     state_d = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: begin
        if (rdy) accept = 1'b1;
      end
      S_LOAD: begin
        state_d = S_SETTLE;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_CHECK;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CHECK: begin
        if (docnt[int'(ch_q)*TAP_W +: TAP_W] != cur_tap_q)
          err_ch_d = err_ch_q | (NUM_CH'(1) << ch_q);
        if (nxt[5]) begin
          do_load = 1'b1;
          load_ch = nxt[4:0];
        end else if (!mode_q || restore_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DWELL;
          cnt_d   = CNT_W'(DWELL_CYCLES - 1);
          step_d  = 1'b1;
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (cur_tap_q == TAP_MAX) begin
          // The sweep ends at TAP_MAX; the restore pass reapplies the target.
          cur_tap_d = target_q;
          restore_d = 1'b1;
          state_d   = S_RESTORE;
        end else begin
          cur_tap_d = cur_tap_q + TAP_W'(1);
          do_load   = 1'b1;
          load_ch   = first[4:0];
          load_tap  = cur_tap_q + TAP_W'(1);
        end
      end
      S_RESTORE: begin
        do_load = 1'b1;
        load_ch = first[4:0];
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      err_ch_d  = '0;
      err_rdy_d = 1'b0;
      restore_d = 1'b0;
      cur_tap_d = src_mode ? '0 : src_tap;
      first_src = next_masked(MAX_CH'(src_mask), 6'd0);
      if (first_src[5]) begin
        do_load  = 1'b1;
        load_ch  = first_src[4:0];
        load_tap = src_mode ? '0 : src_tap;
      end else begin
        state_d = S_DONE;
      end
    end

    // Losing IDELAYCTRL ready aborts the operation; dicnt keeps its values.
    if (!rdy && (state_q inside {S_LOAD, S_SETTLE, S_CHECK, S_DWELL, S_RESTORE})) begin
      state_d   = S_DONE;
      err_rdy_d = 1'b1;
      err_ch_d  = err_ch_q;
      cur_tap_d = cur_tap_q;
      restore_d = restore_q;
      cnt_d     = cnt_q;
      step_d    = 1'b0;
      do_load   = 1'b0;
    end

    if (do_load) begin
      state_d = S_LOAD;
      ch_d    = load_ch;
      ldcnt_d = NUM_CH'(1) << load_ch;
      dicnt_d[int'(load_ch)*TAP_W +: TAP_W] = load_tap;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      mask_q    <= '0;
      target_q  <= '0;
      ch_q      <= '0;
      cur_tap_q <= '0;
      cnt_q     <= '0;
      err_ch_q  <= '0;
      err_rdy_q <= 1'b0;
      ldcnt_q   <= '0;
      dicnt_q   <= '0;
      step_q    <= 1'b0;
      restore_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      target_q  <= target_d;
      ch_q      <= ch_d;
      cur_tap_q <= cur_tap_d;
      cnt_q     <= cnt_d;
      err_ch_q  <= err_ch_d;
      err_rdy_q <= err_rdy_d;
      ldcnt_q   <= ldcnt_d;
      dicnt_q   <= dicnt_d;
      step_q    <= step_d;
      restore_q <= restore_d;
    end
  end

  // A strobe already in flight is suppressed the moment ready drops.
  assign ldcnt     = rdy ? ldcnt_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err_ch    = err_ch_q;
  assign err_rdy   = err_rdy_q;
  assign dicnt     = dicnt_q;
  assign cur_tap   = cur_tap_q;
  assign step_stb  = step_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_idelay_tap_sequencer.sv
// Bench for idelay_tap_sequencer: vector table of load/sweep operations plus
// hand-written sequences for ready loss, late ready, empty mask and reset.
module tb_idelay_tap_sequencer;
  import idelay_seq_pkg::*;

  localparam int NUM_CH = 4;
  localparam int TAP_W  = 5;
  localparam int SETTLE = 4;
  localparam int DWELL  = 16;

  logic                    clk, resetb, rdy, start, mode;
  logic [NUM_CH-1:0]       ch_mask;
  logic [TAP_W-1:0]        tap_target;
  logic                    busy, done, err_rdy, step_stb;
  logic [NUM_CH-1:0]       err_ch, ldcnt;
  logic [NUM_CH*TAP_W-1:0] dicnt, docnt;
  logic [TAP_W-1:0]        cur_tap;
  logic [2:0]              dbg_state;

  idelay_tap_sequencer #(
    .NUM_CH(NUM_CH), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE),
    .DWELL_CYCLES(DWELL), .CNT_W(16)
  ) dut (
    .clk(clk), .resetb(resetb), .rdy(rdy), .start(start), .mode(mode),
    .ch_mask(ch_mask), .tap_target(tap_target), .busy(busy), .done(done),
    .err_ch(err_ch), .err_rdy(err_rdy), .ldcnt(ldcnt), .dicnt(dicnt),
    .docnt(docnt), .cur_tap(cur_tap), .step_stb(step_stb), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  logic [NUM_CH+TAP_W-1:0] exp_q[$];
  int   step_seen;
  logic [TAP_W-1:0] step_exp;

  // io_delay_module readback model: mirrors dicnt, optionally one slice forced
  logic             frc_en;
  int               frc_ch;
  logic [TAP_W-1:0] frc_val;
  always_comb begin
    docnt = dicnt;
    if (frc_en) docnt[frc_ch*TAP_W +: TAP_W] = frc_val;
  end

  typedef struct {
    logic              mode;
    logic [NUM_CH-1:0] mask;
    logic [TAP_W-1:0]  tap;
    logic              frc;
    int                frc_ch;
    logic [TAP_W-1:0]  frc_val;
    logic [NUM_CH-1:0] exp_err;
    int                exp_steps;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(input logic m, input logic [NUM_CH-1:0] mk);
    int n;
    n = $countones(mk);
    if (n == 0) return 1;
    if (!m) return 1 + n * (SETTLE + 2);
    return 2 + 32 * (n * (SETTLE + 2) + DWELL) + n * (SETTLE + 2);
  endfunction

  task automatic push_exp(input logic m, input logic [NUM_CH-1:0] mk,
                          input logic [TAP_W-1:0] tt, input int last_tap);
    logic [NUM_CH-1:0] oh;
    if (!m) begin
      for (int c = 0; c < NUM_CH; c++)
        if (mk[c]) begin oh = NUM_CH'(1) << c; exp_q.push_back({oh, tt}); end
    end else begin
      for (int t = 0; t <= last_tap; t++)
        for (int c = 0; c < NUM_CH; c++)
          if (mk[c]) begin oh = NUM_CH'(1) << c; exp_q.push_back({oh, TAP_W'(t)}); end
      if (last_tap == 31)
        for (int c = 0; c < NUM_CH; c++)
          if (mk[c]) begin oh = NUM_CH'(1) << c; exp_q.push_back({oh, tt}); end
    end
  endtask

  // scoreboard pop on every load strobe, step strobe tracking
  always @(negedge clk) begin
    int ch;
    logic [NUM_CH+TAP_W-1:0] e;
    if (resetb && ldcnt != '0) begin
      ch = 0;
      for (int i = 0; i < NUM_CH; i++) if (ldcnt[i]) ch = i;
      chk("ldcnt_onehot", $countones(ldcnt), 1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ldcnt_unexpected actual=%0d required=none", ldcnt);
      end else begin
        e = exp_q.pop_front();
        chk("ldcnt_dicnt", {ldcnt, dicnt[ch*TAP_W +: TAP_W]}, e);
      end
    end
    if (resetb && step_stb) begin
      chk("step_tap", cur_tap, step_exp);
      step_exp = step_exp + 1'b1;
      step_seen++;
    end
  end

  task automatic run_vec(input vec_t v);
    int cyc;
    frc_en = v.frc; frc_ch = v.frc_ch; frc_val = v.frc_val;
    push_exp(v.mode, v.mask, v.tap, 31);
    step_seen = 0; step_exp = '0;
    mode = v.mode; ch_mask = v.mask; tap_target = v.tap; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    // inputs move after the request; the latched copy must be used
    mode = 1'($urandom_range(0, 1));
    ch_mask = NUM_CH'($urandom_range(0, 15));
    tap_target = TAP_W'($urandom_range(0, 31));
    chk("busy_first", busy, 1);
    while (!done && cyc < 2000) begin
      start = (cyc == 3);
      tick;
      cyc++;
    end
    start = 1'b0;
    chk("done_cycle", cyc, exp_latency(v.mode, v.mask));
    chk("err_ch", err_ch, v.exp_err);
    chk("err_rdy", err_rdy, 0);
    for (int c = 0; c < NUM_CH; c++)
      if (v.mask[c]) chk("dicnt_final", dicnt[c*TAP_W +: TAP_W], v.tap);
    chk("step_count", step_seen, v.exp_steps);
    tick;
    chk("idle_after", {busy, done}, 0);
    chk("sb_empty", exp_q.size(), 0);
    exp_q.delete();
    frc_en = 1'b0;
  endtask

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 4'b0001, 5'd13, 1'b0, 0, 5'd0, 4'b0000, 0};
    vecs[1] = '{1'b0, 4'b1010, 5'd7,  1'b1, 3, 5'd6, 4'b1000, 0};
    vecs[2] = '{1'b0, 4'b0000, 5'd5,  1'b0, 0, 5'd0, 4'b0000, 0};
    vecs[3] = '{1'b0, 4'b1111, 5'd31, 1'b0, 0, 5'd0, 4'b0000, 0};
    vecs[4] = '{1'b0, 4'b0100, 5'd0,  1'b1, 2, 5'd1, 4'b0100, 0};
    vecs[5] = '{1'b1, 4'b0101, 5'd20, 1'b0, 0, 5'd0, 4'b0000, 32};

    resetb = 1'b0; rdy = 1'b1; start = 1'b0; mode = 1'b0;
    ch_mask = '0; tap_target = '0; frc_en = 1'b0; frc_ch = 0; frc_val = '0;
    step_seen = 0; step_exp = '0;
    tick; tick; tick;
    chk("rst_busy_done", {busy, done, err_rdy, step_stb}, 0);
    chk("rst_ldcnt_errch", {ldcnt, err_ch}, 0);
    chk("rst_dicnt", dicnt, 0);
    chk("rst_cur_tap", cur_tap, 0);
    resetb = 1'b1;
    tick;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start while rdy is low: wait in WAIT_RDY, then a normal load
    rdy = 1'b0; mode = 1'b0; ch_mask = 4'b0010; tap_target = 5'd9; start = 1'b1;
    push_exp(1'b0, 4'b0010, 5'd9, 0);
    tick;
    start = 1'b0;
    chk("wait_busy", busy, 1);
    chk("wait_state", dbg_state, S_WAIT_RDY);
    for (int i = 0; i < 9; i++) begin
      start = (i == 4);
      tick;
    end
    start = 1'b0;
    chk("wait_no_load", exp_q.size(), 1);
    chk("wait_still", {busy, dbg_state}, {1'b1, S_WAIT_RDY});
    rdy = 1'b1;
    tick;
    cyc = 1;
    while (!done && cyc < 200) begin tick; cyc++; end
    chk("wait_done_cycle", cyc, 1 + SETTLE + 2);
    chk("wait_errs", {err_rdy, err_ch}, 0);
    chk("wait_dicnt", dicnt[1*TAP_W +: TAP_W], 9);
    tick;
    chk("wait_sb_empty", exp_q.size(), 0);

    // ready lost during sweep dwell at tap 9
    step_seen = 0; step_exp = '0;
    push_exp(1'b1, 4'b0101, 5'd20, 9);
    mode = 1'b1; ch_mask = 4'b0101; tap_target = 5'd20; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!(step_stb && cur_tap == 5'd9) && cyc < 2000) begin tick; cyc++; end
    chk("abort_reach_tap9", cyc < 2000, 1);
    rdy = 1'b0;
    tick;
    chk("abort_done", done, 1);
    chk("abort_err_rdy", err_rdy, 1);
    chk("abort_ldcnt", ldcnt, 0);
    chk("abort_dicnt0", dicnt[0 +: TAP_W], 9);
    chk("abort_dicnt2", dicnt[2*TAP_W +: TAP_W], 9);
    tick;
    chk("abort_idle", {busy, done, ldcnt}, 0);
    chk("abort_err_sticky", err_rdy, 1);
    chk("abort_steps", step_seen, 10);
    chk("abort_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    rdy = 1'b1;
    tick;

    // reset asserted mid-SETTLE
    mode = 1'b0; ch_mask = 4'b0001; tap_target = 5'd13; start = 1'b1;
    push_exp(1'b0, 4'b0001, 5'd13, 0);
    tick;
    start = 1'b0;
    tick;
    chk("rst_mid_state", dbg_state, S_SETTLE);
    #2;
    resetb = 1'b0;
    #1;
    chk("rst_mid_busy_done", {busy, done, err_rdy, step_stb}, 0);
    chk("rst_mid_dicnt", dicnt, 0);
    chk("rst_mid_cur_tap", cur_tap, 0);
    chk("rst_mid_ldcnt", {ldcnt, err_ch}, 0);
    @(posedge clk);
    #1;
    resetb = 1'b1;
    tick;
    chk("rst_release_idle", {busy, dbg_state}, {1'b0, S_IDLE});
    chk("rst_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idelay_tap_sequencer.md
Name: idelay_tap_sequencer

Overview:
- Sequences tap loads into the 4-channel io_delay_module on behalf of the MicroBlaze GPIO, replacing direct software toggling of ldcnt/dicnt.
- Two modes:
  - Load: writes one tap to every masked channel and verifies the docnt readback.
  - Sweep: steps taps 0..TAP_MAX across the masked channels, dwells at each step for capture, then restores the target tap.
- Runs in the 200 MHz clk_io_ref domain, between the GPIO registers and io_delay_module.

Parameters:
- NUM_CH, 4, number of delay channels
- TAP_W, 5, tap value width (TAP_MAX = 2^TAP_W-1 = 31)
- SETTLE_CYCLES, 4, wait after ldcnt before readback compare (min 1)
- DWELL_CYCLES, 16, hold time per sweep step (min 1)
- CNT_W, 16, settle/dwell counter width

Ports:
- clk  in  1  clk_io_ref, 200 MHz
- resetb  in  1  asynchronous active-low reset
- rdy  in  1  IDELAYCTRL ready from io_delay_module
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = load, 1 = sweep
- ch_mask  in  NUM_CH  channels to operate on
- tap_target  in  TAP_W  load value / post-sweep restore value
- busy  out  1  high from first non-IDLE cycle through DONE
- done  out  1  one-cycle pulse at completion or abort
- err_ch  out  NUM_CH  sticky readback-mismatch flags; cleared on accepted start
- err_rdy  out  1  sticky abort flag (rdy lost while busy); cleared on accepted start
- ldcnt  out  NUM_CH  one-hot tap-load strobes
- dicnt  out  NUM_CH*TAP_W  per-channel tap values; channel n at [n*TAP_W +: TAP_W]
- docnt  in  NUM_CH*TAP_W  current tap readback from io_delay_module
- cur_tap  out  TAP_W  tap currently being applied
- step_stb  out  1  one-cycle pulse at entry to each sweep DWELL (ILA trigger)

Behaviour:
- Reset: all outputs 0, dicnt slices 0, state IDLE.
- Register file: mode, mask and tap_target are latched on an accepted start. Later input changes are ignored until the next start.
- States: IDLE, WAIT_RDY, LOAD, SETTLE, CHECK, DWELL, RESTORE, DONE.
- IDLE:
  - start=1 with rdy=1 goes to LOAD (or to DONE if mask==0).
  - start=1 with rdy=0 goes to WAIT_RDY.
  - Accepted start clears err_ch and err_rdy.
- WAIT_RDY: stays until rdy=1, then behaves as an accepted start from IDLE. start is ignored here.
- Channel iteration: masked channels are processed in ascending index order, one channel per LOAD→SETTLE→CHECK pass.
- LOAD:
  - Exactly one cycle.
  - ldcnt[ch]=1, dicnt slice ch <= cur_tap (registered, held afterwards).
  - Never more than one ldcnt bit high.
- SETTLE: SETTLE_CYCLES cycles.
- CHECK:
  - One cycle.
  - If docnt slice ≠ cur_tap, set err_ch[ch].
  - Next: the next masked channel's LOAD; else, after the last channel, DONE (load mode), DWELL (sweep), or DONE (after RESTORE).
- Sweep mode:
  - cur_tap starts at 0.
  - After the last channel at each tap: DWELL for DWELL_CYCLES, with step_stb on its first cycle.
  - Then cur_tap+1 and a new channel pass.
  - After the tap-31 dwell: no wrap to 0; cur_tap <= tap_target, enter RESTORE.
  - RESTORE runs one more pass over all masked channels, then DONE.
- Load mode: cur_tap = tap_target for the whole operation.
- DONE: one cycle, done=1, busy=1. The next cycle is IDLE with busy=0.
- Load-mode latency, one channel, start sampled at cycle 0:
  - ldcnt at cycle 1
  - CHECK at cycle 2+SETTLE_CYCLES
  - done at cycle 3+SETTLE_CYCLES (7 at default)
- rdy falls while busy (any state except DONE):
  - Set err_rdy.
  - Go to DONE next cycle; ldcnt forced 0.
  - dicnt keeps its last values.
- start while busy: ignored, no queueing.
- resetb asserted mid-operation: immediate return to reset values, including dicnt=0. No partial done pulse.
- Counters: saturate-free down-counters of CNT_W bits, loaded with PARAM-1.

Decomposition:
- Package idelay_seq_pkg holds:
  - state encoding constants
  - default TAP_W / NUM_CH
  - function for the next-masked-channel search (priority encoder above the current index)
- No sub-module is needed. The existing COUNTER module is not reused because a loadable down-count is required.

Test Plan:
- Load, mask=4'b0001, tap_target=5'd13, docnt mirrors dicnt:
  - ldcnt=0001 at cycle 1, dicnt[4:0]=13
  - done at cycle 7
  - err_ch=0
- Load, mask=4'b1010, tap_target=5'd7, docnt slice 3 forced to 6:
  - ldcnt=0010 then 1000 on separate cycles
  - err_ch=4'b1000
  - done after 2 passes, at cycle 13
- Sweep, mask=4'b0101, tap_target=5'd20:
  - exactly 32 step_stb pulses, cur_tap 0..31 on them
  - no wrap
  - final dicnt slices 0 and 2 = 20
  - err_ch=0
- start with rdy=0:
  - busy=1 in WAIT_RDY, no ldcnt
  - rdy raised 10 cycles later, then normal load completes
- rdy dropped during sweep at tap 9:
  - err_rdy=1 and done next cycle
  - ldcnt stays 0
  - dicnt holds 9
- mask=0 start → done pulse at cycle 1, no ldcnt. Reset asserted mid-SETTLE → all outputs 0 asynchronously, IDLE after release.
